// File: rtl/gpu_op_queue_pkg.sv
// Shared types for the GPU command queue: draw operation, queued entry and pointer sizing.
package gpu_op_queue_pkg;

  typedef struct packed {
    logic [3:0] opcode;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] color;
  } gpu_op_t;

  typedef struct packed {
    logic    last;
    gpu_op_t op;
  } gpu_queue_entry_t;

  // Pointer width for a RAM of depth-1 entries, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/gpu_op_queue_sdp_ram.sv
// Simple dual-port RAM with synchronous read; no reset on the array so it maps to block RAM.
module sdp_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 15,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/gpu_op_queue.sv
// Draw-operation queue in front of the GPU: RAM backing store plus a head register,
// valid/ready pop side, frame_done pulse on frame-end entries, sticky overflow.
module gpu_op_queue
  import gpu_op_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   flush,
  input  gpu_op_t                push_op,
  input  logic                   push_last,
  input  logic                   push_valid,
  output logic                   push_ready,
  output gpu_op_t                op,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned EW = $bits(gpu_queue_entry_t);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 2);

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  gpu_queue_entry_t head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;
  logic             fwd_q, fwd_d;
  gpu_queue_entry_t fwd_data_q, fwd_data_d;

  logic             full, push, pop, flush_now, ram_empty;
  logic             head_take, load_ram, load_byp, wr_en, ram_we;
  logic [EW-1:0]    ram_rdata;
  gpu_queue_entry_t ram_out, push_entry;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count_q == CW'(DEPTH));
  assign push_entry = '{last: push_last, op: push_op};
  // A write landing on the slot being read this edge is not visible in the RAM output yet.
  assign ram_out    = fwd_q ? fwd_data_q : gpu_queue_entry_t'(ram_rdata);

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_d       = head_q;
    head_valid_d = head_valid_q;
    frame_done_d = frame_done_q;
    overflow_d   = overflow_q;
    fwd_data_d   = fwd_data_q;

    flush_now = ce && flush;
    push      = ce && push_valid && !full;
    pop       = ce && head_valid_q && op_ready;
    ram_empty = (count_q == CW'(head_valid_q));
    head_take = ce && (!head_valid_q || pop);
    load_ram  = head_take && !ram_empty;
    load_byp  = head_take && ram_empty && push;
    wr_en     = push && !load_byp;

    if (load_ram) begin
      head_d       = ram_out;
      head_valid_d = 1'b1;
      rd_ptr_d     = inc_ptr(rd_ptr_q);
    end else if (load_byp) begin
      head_d       = push_entry;
      head_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end

    if (wr_en) begin
      wr_ptr_d   = inc_ptr(wr_ptr_q);
      fwd_data_d = push_entry;
    end

    count_d = count_q + CW'(push) - CW'(pop);

    if (ce) begin
      frame_done_d = pop && head_q.last;
      if (push_valid && full) overflow_d = 1'b1;
    end

    if (flush_now) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
      frame_done_d = 1'b0;
      overflow_d   = 1'b0;
    end

    ram_we = wr_en && !flush_now;
    fwd_d  = ram_we && (wr_ptr_q == rd_ptr_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      fwd_q        <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      fwd_q        <= fwd_d;
      fwd_data_q   <= fwd_data_d;
    end
  end

  sdp_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH - 1),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (push_entry),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  assign push_ready = !full;
  assign op         = head_q.op;
  assign op_valid   = head_valid_q;
  assign count      = count_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_gpu_op_queue.sv
// Directed bench for gpu_op_queue: reset, bypass, fill/overflow, drain, streaming, flush, ce, async reset.
module tb_gpu_op_queue;
  import gpu_op_queue_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  logic    ce = 1'b0;
  logic    flush = 1'b0;
  gpu_op_t push_op = '0;
  logic    push_last = 1'b0;
  logic    push_valid = 1'b0;
  logic    push_ready;
  gpu_op_t op;
  logic    op_valid;
  logic    op_ready = 1'b0;
  logic [4:0] count;
  logic    frame_done;
  logic    overflow;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gpu_op_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .flush      (flush),
    .push_op    (push_op),
    .push_last  (push_last),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .op         (op),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .count      (count),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  function automatic gpu_op_t mk(input int unsigned x, input int unsigned y);
    gpu_op_t r;
    r.opcode = 4'(x + 3);
    r.x      = 10'(x);
    r.y      = 10'(y);
    r.color  = 8'(x + y);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ce = 1'b1;
    tick();
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (op !== gpu_op_t'('0)) begin bad++; $display("FAIL reset_op got=%h exp=0", op); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push_op = mk(10, 20); push_last = 1'b1; push_valid = 1'b1; op_ready = 1'b1;
    tick();
    push_valid = 1'b0; push_last = 1'b0;
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", op_valid); end
    total++; if (op.x !== 10'd10 || op.y !== 10'd20) begin
      bad++; $display("FAIL single_fields got=%0d/%0d exp=10/20", op.x, op.y); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", count); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL single_fd_early got=%b exp=0", frame_done); end
    tick();
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%b exp=0", op_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", count); end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL single_fd got=%b exp=1", frame_done); end
    op_ready = 1'b0;
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL single_fd_drop got=%b exp=0", frame_done); end
  endtask

  task automatic test_fill();
    op_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_op = mk(i, i + 100); push_last = ((i % 4) == 3); push_valid = 1'b1;
      tick();
    end
    push_valid = 1'b0; push_last = 1'b0;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", count); end
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", push_ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
    total++; if (op_valid !== 1'b1 || op.x !== 10'd0) begin
      bad++; $display("FAIL fill_head got=%b/%0d exp=1/0", op_valid, op.x); end
    push_op = mk(99, 99); push_valid = 1'b1;
    tick();
    push_valid = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_ovf_count got=%0d exp=16", count); end
    total++; if (op.x !== 10'd0) begin bad++; $display("FAIL fill_head_hold got=%0d exp=0", op.x); end
  endtask

  task automatic test_drain();
    op_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (op_valid !== 1'b1 || op.x !== 10'(i) || op.y !== 10'(i + 100)) begin
        bad++; $display("FAIL drain_head[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", i, op_valid, op.x, op.y, i, i + 100); end
      tick();
      total++; if (frame_done !== ((i % 4) == 3)) begin
        bad++; $display("FAIL drain_fd[%0d] got=%b exp=%b", i, frame_done, ((i % 4) == 3)); end
      if (i == 0) begin
        total++; if (push_ready !== 1'b1 || count !== 5'd15) begin
          bad++; $display("FAIL drain_first got=%b/%0d exp=1/15", push_ready, count); end
      end
    end
    op_ready = 1'b0;
    total++; if (count !== 5'd0 || op_valid !== 1'b0) begin
      bad++; $display("FAIL drain_empty got=%0d/%b exp=0/0", count, op_valid); end
  endtask

  task automatic test_stream();
    gpu_queue_entry_t exp_q[$];
    int sent = 0;
    int recv = 0;
    int frames = 0;
    int cycles = 0;
    logic exp_fd;
    logic do_push, do_pop;
    while ((sent < 48 || exp_q.size() > 0) && cycles < 2000) begin
      push_valid = (sent < 48);
      push_op    = mk(sent + 200, sent * 3);
      push_last  = ((sent % 3) == 2);
      op_ready   = 1'($urandom_range(0, 1));
      do_push = push_valid && (exp_q.size() < DEPTH);
      do_pop  = (exp_q.size() > 0) && op_ready;
      exp_fd  = 1'b0;
      if (do_pop) begin
        total++; if (op_valid !== 1'b1 || op !== exp_q[0].op) begin
          bad++; $display("FAIL stream_op[%0d] got=%b/%h exp=1/%h", recv, op_valid, op, exp_q[0].op); end
        exp_fd = exp_q[0].last;
        void'(exp_q.pop_front());
        recv++;
      end
      if (do_push) begin
        exp_q.push_back('{last: push_last, op: push_op});
        sent++;
      end
      tick();
      cycles++;
      if (frame_done === 1'b1) frames++;
      total++; if (frame_done !== exp_fd) begin
        bad++; $display("FAIL stream_fd[%0d] got=%b exp=%b", cycles, frame_done, exp_fd); end
      total++; if (count !== 5'(exp_q.size())) begin
        bad++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", cycles, count, exp_q.size()); end
    end
    push_valid = 1'b0; push_last = 1'b0; op_ready = 1'b0;
    total++; if (cycles >= 2000) begin bad++; $display("FAIL stream_timeout got=%0d exp<2000", cycles); end
    total++; if (recv != 48) begin bad++; $display("FAIL stream_recv got=%0d exp=48", recv); end
    total++; if (frames != 16) begin bad++; $display("FAIL stream_frames got=%0d exp=16", frames); end
  endtask

  task automatic test_flush();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL flush_pre_ovf got=%b exp=1", overflow); end
    op_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_op = mk(300 + i, 0); push_last = 1'b1; push_valid = 1'b1;
      tick();
    end
    total++; if (count !== 5'd5) begin bad++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    push_op = mk(400, 0); flush = 1'b1; op_ready = 1'b1;
    tick();
    flush = 1'b0; push_valid = 1'b0; push_last = 1'b0; op_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", op_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b exp=0", overflow); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL flush_fd got=%b exp=0", frame_done); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", push_ready); end
  endtask

  task automatic test_ce();
    push_op = mk(100, 1); push_last = 1'b1; push_valid = 1'b1;
    tick();
    push_op = mk(101, 1); push_last = 1'b0;
    tick();
    push_op = mk(102, 1); op_ready = 1'b1;
    tick();
    total++; if (frame_done !== 1'b1 || op.x !== 10'd101 || count !== 5'd2) begin
      bad++; $display("FAIL ce_pre got=%b/%0d/%0d exp=1/101/2", frame_done, op.x, count); end
    ce = 1'b0; push_op = mk(103, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (count !== 5'd2 || op.x !== 10'd101 || op_valid !== 1'b1 || frame_done !== 1'b1) begin
        bad++; $display("FAIL ce_hold[%0d] got=%0d/%0d/%b/%b exp=2/101/1/1", i, count, op.x, op_valid, frame_done); end
    end
    ce = 1'b1; push_valid = 1'b0; op_ready = 1'b0;
    tick();
    total++; if (frame_done !== 1'b0 || count !== 5'd2 || op.x !== 10'd101) begin
      bad++; $display("FAIL ce_resume got=%b/%0d/%0d exp=0/2/101", frame_done, count, op.x); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (count !== 5'd0 || op_valid !== 1'b0 || push_ready !== 1'b1) begin
      bad++; $display("FAIL async_rst got=%0d/%b/%b exp=0/0/1", count, op_valid, push_ready); end
    total++; if (op !== gpu_op_t'('0) || frame_done !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL async_rst_out got=%h/%b/%b exp=0/0/0", op, frame_done, overflow); end
    tick();
    rst = 1'b1;
    tick();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL post_rst_count got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_ce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_op_queue.md
# gpu_op_queue

Command queue directly upstream of `gpu`: scene/game logic pushes `gpu_op_t` draw operations, and the queue buffers them and presents them one at a time to `gpu` on a valid/ready handshake. Each operation carries a frame-end marker. The queue pulses `frame_done` when the last operation of a frame has been handed to `gpu`, which lets the frame sequencer schedule the buffer swap. Everything is gated by the shared clock-enable `ce`.

## Interface
- `DEPTH`, 16: total entries, power of two and at least 2, including the output register.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; deasserted synchronously by the reset block.
- `ce`  in  1  clock enable; when low, all state holds and no handshake completes.
- `flush`  in  1  synchronous clear of every entry; sampled only when `ce` is high.
- `push_op`  in  `$bits(gpu_op_t)`  operation to enqueue.
- `push_last`  in  1  marks `push_op` as the final operation of a frame.
- `push_valid`  in  1  producer offers `push_op`/`push_last`.
- `push_ready`  out  1  queue can accept; equals `!full`.
- `op`  out  `$bits(gpu_op_t)`  head operation to `gpu`.
- `op_valid`  out  1  head register holds a valid entry.
- `op_ready`  in  1  `gpu` accepts the head.
- `count`  out  `$clog2(DEPTH)+1`  number of occupied entries, including the head.
- `frame_done`  out  1  one-cycle pulse after a `last` entry transfers.
- `overflow`  out  1  sticky flag: `push_valid` was high while `full`; cleared by reset or `flush`.

## Operation
- Storage: a RAM of `DEPTH-1` entries plus a head output register. Each entry is `{last, gpu_op_t}`.
- Transfer events:
  - push = `ce && push_valid && push_ready`
  - pop = `ce && op_valid && op_ready`
- Head refill: when the head is empty, or a pop occurs, and the RAM is non-empty, the head loads the RAM entry at the read pointer. Otherwise, when the head is empty or popping, the RAM is empty, and a push occurs, the head loads `push_op` directly (bypass).
- Pointers: read and write pointers are `$clog2(DEPTH-1)`-bit and wrap modulo `DEPTH-1`. Fullness is judged by `count`, never by pointer compare. For `DEPTH-1` not a power of two, the pointer wraps explicitly at `DEPTH-2`.
- `count`: next value is `count + push - pop`. Simultaneous push and pop leaves `count` unchanged.
- `full` = (`count == DEPTH`). A pop in the same cycle does not free a slot for a push; `push_ready` stays low for that cycle.
- `frame_done` is registered: high for exactly one `ce` cycle after a pop whose head entry had `last` = 1, low otherwise.
- `flush` has priority over push and pop in the same cycle. It empties the queue, clears `overflow`, and suppresses `frame_done` for that cycle.
- Pushing a `last` entry into an empty queue is legal; a frame of a single op yields one `frame_done`.

## Timing
- Reset values: `op` = 0, `op_valid` = 0, `count` = 0, `push_ready` = 1, `frame_done` = 0, `overflow` = 0; pointers = 0.
- Reset asserted mid-operation discards all entries immediately (asynchronously). Outputs take their reset values without waiting for a clock edge.
- Latency, empty queue: push at edge N gives `op_valid` = 1 after edge N (bypass), so the head is visible in cycle N+1.
- Latency, non-empty RAM: after a pop at edge N, the next head is valid after edge N. Back-to-back pops at one per cycle are sustained.
- RAM read is synchronous. The read pointer is pre-advanced so that the RAM read data for the next head is already available at the pop edge. A wait cycle on the pop side is not permitted.
- `op` and `op_valid` are stable while `op_valid && !op_ready`. `op` is don't-care when `op_valid` = 0, but it is driven from a register, never from X.
- With `ce` low, inputs are ignored and every output holds its value. A pending `frame_done` pulse is extended until the next `ce` cycle, then drops.

## Structure
- `gpu_op_t` lives in the shared `gpu_op_t.sv` header already used by `gpu`.
- New typedef `gpu_queue_entry_t` = `{logic last; gpu_op_t op;}` goes in the same header.
- One sub-module: `sdp_ram` (simple dual-port, synchronous read, width `$bits(gpu_queue_entry_t)`, depth `DEPTH-1`). It is inferable as block RAM and has no reset on the array.
- The pointer/count/head logic stays in `gpu_op_queue` as a single `always_ff` with async active-low reset.

## Test plan
- Reset then single push (`x`=10, `y`=20, `last`=1) with `op_ready` = 1 → `op_valid` in the next cycle with matching fields, one `frame_done` pulse one cycle after the pop, `count` returning 1 → 0.
- Push 16 ops with `DEPTH` = 16 and `op_ready` = 0 → `count` = 16, `push_ready` = 0. A 17th push sets `overflow` = 1 and `count` stays 16.
- Full queue, `op_ready` = 1 for 16 cycles → ops emerge in push order at one per cycle, and `push_ready` rises after the first pop cycle.
- Continuous push and pop with random `op_ready` across 3×`DEPTH` ops → order preserved through pointer wrap, no loss or duplication, and one `frame_done` per `last` marker.
- `flush` asserted together with push and pop at `count` = 5 → next cycle `count` = 0, `op_valid` = 0, `overflow` = 0, no `frame_done`.
- `ce` low for 4 cycles while `push_valid` and `op_ready` are high → no state change. Assert async reset mid-stream → outputs at reset values before the next clock edge.
